tlb_lu_arbiter: RTL
===================

TLB_LU_ARBITER -- requirements
Module: tlb_lu_arbiter

Interface
REQ-001 SHALL have parameter NR_REQ, default 2, number of lookup requesters (2..4).
REQ-002 SHALL have parameter ASID_WIDTH, default 1, ASID width passed to the TLB.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 req_valid_i  in  NR_REQ  per-requester lookup request; held until granted.
REQ-006 req_asid_i  in  NR_REQ x ASID_WIDTH  per-requester ASID.
REQ-007 req_vaddr_i  in  NR_REQ x riscv::VLEN  per-requester virtual address.
REQ-008 req_ready_o  out  NR_REQ  grant; at most one bit set per cycle.
REQ-009 resp_valid_o  out  NR_REQ  one-cycle response strobe to the granted requester.
REQ-010 resp_hit_o, resp_is_2M_o, resp_is_1G_o  out  1 each  registered lookup result.
REQ-011 resp_content_o  out  riscv::pte_t  registered PTE.
REQ-012 lu_access_o, lu_asid_o, lu_vaddr_o  out  1/ASID_WIDTH/VLEN  TLB lookup port.
REQ-013 lu_hit_i, lu_is_2M_i, lu_is_1G_i, lu_content_i  in  1/1/1/pte_t  TLB combinational result.
REQ-014 flush_req_i, flush_asid_i, flush_vaddr_i  in  1/ASID_WIDTH/VLEN  SFENCE.VMA request, level, operands stable while high.
REQ-015 flush_o, flush_asid_o, flush_vaddr_o  out  1/ASID_WIDTH/VLEN  TLB flush port.
REQ-016 flush_ack_o  out  1  one-cycle pulse when the TLB flush was issued.
REQ-017 update_i  in  tlb_update_t  PTW update; update_ready_o out 1; update_o out tlb_update_t to TLB.
REQ-018 hit_cnt_o, miss_cnt_o  out  32 each  performance counters (see Configuration).

Function
REQ-019 SHALL implement FSM states RUN, FLUSH, WAIT_REL.
REQ-020 RUN, flush_req_i=0: SHALL grant exactly one valid requester, round-robin starting at pointer rr_q.
REQ-021 Grant cycle T: lu_access_o=1, lu_asid_o/lu_vaddr_o = granted requester's operands, req_ready_o[g]=1.
REQ-022 Cycle T+1: resp_valid_o[g]=1 and resp_* = TLB outputs sampled at T; latency exactly 1.
REQ-023 After grant to g, rr_q SHALL become (g+1) mod NR_REQ; unchanged when no grant.
REQ-024 No valid request: lu_access_o=0, lu_asid_o/lu_vaddr_o=0, no req_ready_o.
REQ-025 RUN with flush_req_i=1: SHALL grant nothing that cycle and go to FLUSH; a response due from T-1 is still delivered.
REQ-026 FLUSH (one cycle): flush_o=1, flush_asid_o/flush_vaddr_o = flush inputs, flush_ack_o=1, lu_access_o=0; next WAIT_REL.
REQ-027 WAIT_REL: no grants; return to RUN when flush_req_i=0.
REQ-028 In RUN/WAIT_REL: update_o = update_i, update_ready_o=1; in FLUSH: update_o.valid=0, update_ready_o=0 (PTW holds update).
REQ-029 Outside FLUSH: flush_o=0, flush_asid_o=0, flush_vaddr_o=0.
REQ-030 Grant and update_i.valid in same cycle SHALL both proceed; lookup result is the pre-update TLB state.
REQ-031 rr_q SHALL wrap from NR_REQ-1 to 0.

Reset
REQ-032 rst_i high: state=RUN, rr_q=0, resp_valid_o=0, resp_* =0, counters=0, all outputs 0 except update_ready_o=1, update_o=update_i.
REQ-033 Reset asserted mid-lookup SHALL drop the pending response; no resp_valid_o after release.

Configuration
REQ-034 Macro TLB_LU_ARB_PERF_EN defined: hit_cnt_o/miss_cnt_o SHALL increment at T+1 on each response with hit/miss, wrap at 2^32.
REQ-035 Macro undefined: counters SHALL not exist; hit_cnt_o=miss_cnt_o=0 constantly.

Verification
REQ-036 req_valid_i=2'b11 held, rr_q=0 -> grants 0,1,0,1 on consecutive cycles; resp_valid_o 1 cycle after each.
REQ-037 Single req[1], vaddr=0x0000_4000, lu_hit_i=1, content.ppn=0x123 -> next cycle resp_valid_o=2'b10, resp_hit_o=1, ppn=0x123.
REQ-038 flush_req_i=1 with req_valid_i=2'b01 -> no grant, next cycle flush_o=1 and flush_ack_o=1, no grants until flush_req_i=0.
REQ-039 update_i.valid=1 during FLUSH -> update_o.valid=0, update_ready_o=0; next cycle update_o.valid=1.
REQ-040 rst_i pulsed in the cycle after a grant -> resp_valid_o stays 0, rr_q=0, counters=0.
REQ-041 With TLB_LU_ARB_PERF_EN, 3 hits and 2 misses -> hit_cnt_o=3, miss_cnt_o=2; without it both stay 0.

Source files
------------

// File: rtl/tlb_lu_arbiter_if.sv
// Bundle of requester, TLB lookup/flush/update and counter signals for tlb_lu_arbiter.
// PTE layout is Sv39 (64-bit); VLEN defaults to 39.
interface tlb_lu_arbiter_if #(
    parameter int NR_REQ     = 2,
    parameter int ASID_WIDTH = 1,
    parameter int VLEN       = 39
);
    typedef struct packed {
        logic [9:0]  reserved;
        logic [43:0] ppn;
        logic [1:0]  rsw;
        logic        d, a, g, u, x, w, r, v;
    } pte_t;

    typedef struct packed {
        logic                  valid;
        logic                  is_2M;
        logic                  is_1G;
        logic [26:0]           vpn;
        logic [ASID_WIDTH-1:0] asid;
        pte_t                  content;
    } tlb_update_t;

    logic [NR_REQ-1:0]                 req_valid_i;
    logic [NR_REQ-1:0][ASID_WIDTH-1:0] req_asid_i;
    logic [NR_REQ-1:0][VLEN-1:0]       req_vaddr_i;
    logic [NR_REQ-1:0]                 req_ready_o;
    logic [NR_REQ-1:0]                 resp_valid_o;
    logic                              resp_hit_o, resp_is_2M_o, resp_is_1G_o;
    pte_t                              resp_content_o;

    logic                  lu_access_o;
    logic [ASID_WIDTH-1:0] lu_asid_o;
    logic [VLEN-1:0]       lu_vaddr_o;
    logic                  lu_hit_i, lu_is_2M_i, lu_is_1G_i;
    pte_t                  lu_content_i;

    logic                  flush_req_i;
    logic [ASID_WIDTH-1:0] flush_asid_i;
    logic [VLEN-1:0]       flush_vaddr_i;
    logic                  flush_o;
    logic [ASID_WIDTH-1:0] flush_asid_o;
    logic [VLEN-1:0]       flush_vaddr_o;
    logic                  flush_ack_o;

    tlb_update_t update_i, update_o;
    logic        update_ready_o;
    logic [31:0] hit_cnt_o, miss_cnt_o;

    modport slave (
        input  req_valid_i, req_asid_i, req_vaddr_i,
               lu_hit_i, lu_is_2M_i, lu_is_1G_i, lu_content_i,
               flush_req_i, flush_asid_i, flush_vaddr_i, update_i,
        output req_ready_o, resp_valid_o, resp_hit_o, resp_is_2M_o, resp_is_1G_o, resp_content_o,
               lu_access_o, lu_asid_o, lu_vaddr_o,
               flush_o, flush_asid_o, flush_vaddr_o, flush_ack_o,
               update_o, update_ready_o, hit_cnt_o, miss_cnt_o
    );

    modport master (
        output req_valid_i, req_asid_i, req_vaddr_i,
               lu_hit_i, lu_is_2M_i, lu_is_1G_i, lu_content_i,
               flush_req_i, flush_asid_i, flush_vaddr_i, update_i,
        input  req_ready_o, resp_valid_o, resp_hit_o, resp_is_2M_o, resp_is_1G_o, resp_content_o,
               lu_access_o, lu_asid_o, lu_vaddr_o,
               flush_o, flush_asid_o, flush_vaddr_o, flush_ack_o,
               update_o, update_ready_o, hit_cnt_o, miss_cnt_o
    );
endinterface

// File: rtl/tlb_lu_arbiter.sv
// Round-robin arbiter for TLB lookup requesters with SFENCE.VMA flush sequencing.
// Define TLB_LU_ARB_PERF_EN to build the 32-bit hit/miss counters.
module tlb_lu_arbiter #(
    parameter int NR_REQ     = 2,
    parameter int ASID_WIDTH = 1
) (
    input logic             clk_i,
    input logic             rst_i,
    tlb_lu_arbiter_if.slave bus
);
    localparam int IDX_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

    typedef enum logic [1:0] {RUN, FLUSH, WAIT_REL} state_e;

    state_e            r_state;
    logic [IDX_W-1:0]  r_rr;
    logic [NR_REQ-1:0] r_resp_valid;
    logic              r_hit, r_is_2M, r_is_1G;
    logic [63:0]       r_content;

    logic              w_arb_en, w_gnt, w_in_flush;
    logic [IDX_W-1:0]  w_gnt_idx;
    logic [NR_REQ-1:0] w_ready;

    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NR_REQ) sum -= NR_REQ;
        return IDX_W'(sum);
    endfunction

    // Grants are gated by reset too, so nothing leaks onto the lookup port while held in reset.
    assign w_arb_en   = (r_state == RUN) && !bus.flush_req_i && !rst_i;
    assign w_in_flush = (r_state == FLUSH);

    // Descending scan: the last hit written is the one closest to r_rr.
    always_comb begin
        w_gnt     = 1'b0;
        w_gnt_idx = '0;
        for (int k = NR_REQ - 1; k >= 0; k--) begin
            if (w_arb_en && bus.req_valid_i[rr_idx(r_rr, k)]) begin
                w_gnt     = 1'b1;
                w_gnt_idx = rr_idx(r_rr, k);
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (w_gnt) w_ready[w_gnt_idx] = 1'b1;
    end

    assign bus.req_ready_o    = w_ready;
    assign bus.lu_access_o    = w_gnt;
    assign bus.lu_asid_o      = w_gnt ? bus.req_asid_i[w_gnt_idx] : {ASID_WIDTH{1'b0}};
    assign bus.lu_vaddr_o     = w_gnt ? bus.req_vaddr_i[w_gnt_idx] : '0;

    assign bus.resp_valid_o   = r_resp_valid;
    assign bus.resp_hit_o     = r_hit;
    assign bus.resp_is_2M_o   = r_is_2M;
    assign bus.resp_is_1G_o   = r_is_1G;
    assign bus.resp_content_o = r_content;

    assign bus.flush_o        = w_in_flush;
    assign bus.flush_ack_o    = w_in_flush;
    assign bus.flush_asid_o   = w_in_flush ? bus.flush_asid_i : '0;
    assign bus.flush_vaddr_o  = w_in_flush ? bus.flush_vaddr_i : '0;

    // The PTW holds its update while the TLB is being flushed.
    always_comb begin
        bus.update_o = bus.update_i;
        if (w_in_flush) bus.update_o.valid = 1'b0;
    end
    assign bus.update_ready_o = !w_in_flush;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= RUN;
            r_rr         <= '0;
            r_resp_valid <= '0;
            r_hit        <= 1'b0;
            r_is_2M      <= 1'b0;
            r_is_1G      <= 1'b0;
            r_content    <= '0;
        end else begin
            r_resp_valid <= w_ready;
            if (w_gnt) begin
                r_hit     <= bus.lu_hit_i;
                r_is_2M   <= bus.lu_is_2M_i;
                r_is_1G   <= bus.lu_is_1G_i;
                r_content <= bus.lu_content_i;
                r_rr      <= rr_idx(w_gnt_idx, 1);
            end
            case (r_state)
                RUN:      if (bus.flush_req_i) r_state <= FLUSH;
                FLUSH:    r_state <= WAIT_REL;
                WAIT_REL: if (!bus.flush_req_i) r_state <= RUN;
                default:  r_state <= RUN;
            endcase
        end
    end

`ifdef TLB_LU_ARB_PERF_EN
    logic [31:0] r_hit_cnt, r_miss_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_gnt) begin
            if (bus.lu_hit_i) r_hit_cnt  <= r_hit_cnt + 32'd1;
            else              r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign bus.hit_cnt_o  = r_hit_cnt;
    assign bus.miss_cnt_o = r_miss_cnt;
`else
    assign bus.hit_cnt_o  = '0;
    assign bus.miss_cnt_o = '0;
`endif
endmodule
